// File: rtl/elevator_scan_controller_if.sv
// Call-request and car-status bundle for elevator_scan_controller.
// The estop signal exists only when ELEV_ESTOP_EN is defined.
interface elevator_scan_controller_if #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = 4
);
    logic                  req_valid;
    logic [FLOOR_W-1:0]    req_floor;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  door_open;
    logic                  moving_up;
    logic                  moving_down;
    logic                  arrived;
    logic                  req_err;
    logic [NUM_FLOORS-1:0] pending;
`ifdef ELEV_ESTOP_EN
    logic                  estop;

    modport master (
        output req_valid, req_floor, estop,
        input  current_floor, door_open, moving_up,
        input  moving_down, arrived, req_err, pending
    );
    modport slave (
        input  req_valid, req_floor, estop,
        output current_floor, door_open, moving_up,
        output moving_down, arrived, req_err, pending
    );
`else
    modport master (
        output req_valid, req_floor,
        input  current_floor, door_open, moving_up,
        input  moving_down, arrived, req_err, pending
    );
    modport slave (
        input  req_valid, req_floor,
        output current_floor, door_open, moving_up,
        output moving_down, arrived, req_err, pending
    );
`endif
endinterface

// File: rtl/elevator_scan_controller.sv
// SCAN-order elevator car controller with timed travel and door dwell.
// Optional ELEV_ESTOP_EN adds an emergency-stop freeze input.
module elevator_scan_controller #(
    parameter int NUM_FLOORS    = 16,
    parameter int FLOOR_W       = 4,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 8
) (
    input  logic clk,
    input  logic reset,
    elevator_scan_controller_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MOVE  = 2'd1;
    localparam logic [1:0] S_DWELL = 2'd2;
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;
    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);

    logic [1:0]            state_q, state_d;
    logic                  dir_q, dir_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [TW-1:0]         travel_q, travel_d;
    logic [DW-1:0]         dwell_q, dwell_d;
    logic                  arrived_q, arrived_d;
    logic                  req_err_q, req_err_d;

    logic                  req_ok, here_req;
    logic                  pend_here, pend_next;
    logic                  any_up, any_dn, at_limit;
    logic                  travel_end, dwell_end;
    logic                  clr_en;
    logic [FLOOR_W-1:0]    clr_floor, next_floor;
    logic [NUM_FLOORS-1:0] set_mask, clr_mask;

    always_comb begin
        req_ok     = bus.req_valid &&
                     (int'(bus.req_floor) < NUM_FLOORS);
        here_req   = bus.req_valid &&
                     (bus.req_floor == floor_q);
        next_floor = (dir_q == DIR_UP) ?
                     floor_q + FLOOR_W'(1) :
                     floor_q - FLOOR_W'(1);
        at_limit   = (dir_q == DIR_UP) ?
                     (int'(floor_q) == NUM_FLOORS - 1) :
                     (floor_q == '0);
        travel_end = (travel_q == TW'(TRAVEL_CYCLES - 1));
        dwell_end  = (dwell_q == DW'(DOOR_CYCLES - 1));

        pend_here = 1'b0;
        pend_next = 1'b0;
        any_up    = 1'b0;
        any_dn    = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i == int'(floor_q))    pend_here = pending_q[i];
            if (i == int'(next_floor)) pend_next = pending_q[i];
            if (i > int'(floor_q))     any_up |= pending_q[i];
            if (i < int'(floor_q))     any_dn |= pending_q[i];
        end

        state_d   = state_q;
        dir_d     = dir_q;
        floor_d   = floor_q;
        travel_d  = travel_q;
        dwell_d   = dwell_q;
        arrived_d = 1'b0;
        req_err_d = bus.req_valid && !req_ok;
        clr_en    = 1'b0;
        clr_floor = floor_q;

        unique case (state_q)
            S_IDLE: begin
                if (pend_here) begin
                    state_d   = S_DWELL;
                    dwell_d   = '0;
                    arrived_d = 1'b1;
                    clr_en    = 1'b1;
                end else if ((dir_q == DIR_UP) ? any_up : any_dn) begin
                    state_d  = S_MOVE;
                    travel_d = '0;
                end else if ((dir_q == DIR_UP) ? any_dn : any_up) begin
                    dir_d    = ~dir_q;
                    state_d  = S_MOVE;
                    travel_d = '0;
                end
            end
            S_MOVE: begin
                if (!travel_end) begin
                    travel_d = travel_q + TW'(1);
                end else begin
                    travel_d = '0;
                    // Defensive stop at the shaft ends; no wrap-around.
                    if (at_limit) begin
                        state_d = S_IDLE;
                    end else begin
                        floor_d = next_floor;
                        if (pend_next) begin
                            state_d   = S_DWELL;
                            dwell_d   = '0;
                            arrived_d = 1'b1;
                            clr_en    = 1'b1;
                            clr_floor = next_floor;
                        end
                    end
                end
            end
            S_DWELL: begin
                if (here_req) begin
                    dwell_d = '0;
                end else if (dwell_end) begin
                    state_d = S_IDLE;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef ELEV_ESTOP_EN
        if (bus.estop) begin
            state_d   = state_q;
            dir_d     = dir_q;
            floor_d   = floor_q;
            travel_d  = travel_q;
            dwell_d   = dwell_q;
            arrived_d = 1'b0;
            clr_en    = 1'b0;
        end
`endif

        // Clear beats a same-edge set so no stale call survives arrival.
        set_mask = '0;
        clr_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (req_ok && i == int'(bus.req_floor) &&
                !(state_q == S_DWELL && here_req))
                set_mask[i] = 1'b1;
            if (clr_en && i == int'(clr_floor))
                clr_mask[i] = 1'b1;
        end
        pending_d = (pending_q | set_mask) & ~clr_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dir_q     <= DIR_UP;
            floor_q   <= '0;
            pending_q <= '0;
            travel_q  <= '0;
            dwell_q   <= '0;
            arrived_q <= 1'b0;
            req_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            travel_q  <= travel_d;
            dwell_q   <= dwell_d;
            arrived_q <= arrived_d;
            req_err_q <= req_err_d;
        end
    end

    assign bus.current_floor = floor_q;
    assign bus.pending       = pending_q;
    assign bus.arrived       = arrived_q;
    assign bus.req_err       = req_err_q;
`ifdef ELEV_ESTOP_EN
    assign bus.door_open   = (state_q != S_MOVE) && !bus.estop;
    assign bus.moving_up   = (state_q == S_MOVE) &&
                             (dir_q == DIR_UP) && !bus.estop;
    assign bus.moving_down = (state_q == S_MOVE) &&
                             (dir_q == DIR_DN) && !bus.estop;
`else
    assign bus.door_open   = (state_q != S_MOVE);
    assign bus.moving_up   = (state_q == S_MOVE) && (dir_q == DIR_UP);
    assign bus.moving_down = (state_q == S_MOVE) && (dir_q == DIR_DN);
`endif
endmodule

// File: tb/tb_elevator_scan_controller.sv
// Scoreboard bench for elevator_scan_controller: arrivals and
// req_err pulses are popped from expectation queues by monitors.
module tb_elevator_scan_controller;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   t0 = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    typedef struct {
        int fl;
        int cy;
    } arr_t;

    arr_t arr_q[$];
    arr_t arr12_q[$];
    int   err12_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    elevator_scan_controller_if #(
        .NUM_FLOORS(16), .FLOOR_W(4)) bus ();
    elevator_scan_controller_if #(
        .NUM_FLOORS(12), .FLOOR_W(4)) bus12 ();

    elevator_scan_controller dut (
        .clk(clk), .reset(reset), .bus(bus));
    elevator_scan_controller #(.NUM_FLOORS(12)) dut12 (
        .clk(clk), .reset(reset), .bus(bus12));

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < t0 + n) @(negedge clk);
    endtask

    task automatic start();
        @(negedge clk);
        t0 = cyc;
    endtask

    task automatic expect_arr(input int fl, input int n);
        arr_t e;
        e.fl = fl;
        e.cy = t0 + n;
        arr_q.push_back(e);
    endtask

    task automatic req(input int n, input int fl);
        goto(n);
        bus.req_valid = 1'b1;
        bus.req_floor = 4'(fl);
        goto(n + 1);
        bus.req_valid = 1'b0;
    endtask

    // Monitor for the 16-floor car
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.arrived) begin
                if (arr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL arr_unexpected: floor %0d cycle %0d",
                             bus.current_floor, cyc);
                end else begin
                    arr_t e;
                    e = arr_q.pop_front();
                    chk("arr_floor", bus.current_floor, e.fl);
                    chk("arr_cycle", cyc, e.cy);
                    chk("arr_door", bus.door_open, 1);
                    chk("arr_clear", bus.pending[e.fl], 0);
                end
            end
            if (bus.req_err) begin
                n_tests++;
                n_fail++;
                $display("FAIL err_unexpected: cycle %0d", cyc);
            end
        end
    end

    // Monitor for the 12-floor car
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus12.arrived) begin
                if (arr12_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL arr12_unexpected: cycle %0d", cyc);
                end else begin
                    arr_t e;
                    e = arr12_q.pop_front();
                    chk("arr12_floor", bus12.current_floor, e.fl);
                    chk("arr12_cycle", cyc, e.cy);
                end
            end
            if (bus12.req_err) begin
                if (err12_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL err12_unexpected: cycle %0d", cyc);
                end else begin
                    int c;
                    c = err12_q.pop_front();
                    chk("err12_cycle", cyc, c);
                end
            end
        end
    end

    initial begin
        arr_t e;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_floor = '0;
        bus12.req_valid = 1'b0;
        bus12.req_floor = '0;
`ifdef ELEV_ESTOP_EN
        bus.estop = 1'b0;
        bus12.estop = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("rst_floor", bus.current_floor, 0);
        chk("rst_door", bus.door_open, 1);
        chk("rst_pending", bus.pending, 0);
        chk("rst_up", bus.moving_up, 0);
        chk("rst_dn", bus.moving_down, 0);
        chk("rst_arr", bus.arrived, 0);
        reset = 1'b0;

        // Single call up from floor 0
        start();
        expect_arr(3, 14);
        req(0, 3);
        chk("t1_pend", bus.pending, 16'h0008);
        chk("t1_idle", bus.moving_up, 0);
        goto(2);
        chk("t1_move", bus.moving_up, 1);
        chk("t1_door", bus.door_open, 0);
        goto(6);
        chk("t1_f1", bus.current_floor, 1);
        goto(10);
        chk("t1_f2", bus.current_floor, 2);
        goto(13);
        chk("t1_f2b", bus.current_floor, 2);
        goto(21);
        chk("t1_dwell", bus.door_open, 1);
        expect_arr(4, 27);
        req(21, 4);
        chk("t1_idle22", bus.moving_up, 0);
        goto(23);
        chk("t1_move23", bus.moving_up, 1);
        goto(36);

        // SCAN order from floor 4
        start();
        expect_arr(9, 22);
        expect_arr(12, 43);
        expect_arr(2, 92);
        req(0, 9);
        goto(6);
        chk("t2_f5", bus.current_floor, 5);
        req(7, 2);
        req(8, 12);
        chk("t2_pend", bus.pending, 16'h1204);
        goto(31);
        chk("t2_keep_up", bus.moving_up, 1);
        goto(51);
        chk("t2_idle51", bus.moving_down, 0);
        chk("t2_door51", bus.door_open, 1);
        goto(52);
        chk("t2_down52", bus.moving_down, 1);
        goto(102);

        // Dwell hold at floor 4, duplicate and same-edge request
        start();
        expect_arr(4, 10);
        req(0, 4);
        goto(16);
        chk("t3_door16", bus.door_open, 1);
        req(16, 4);
        chk("t3_p4", bus.pending, 0);
        expect_arr(5, 30);
        req(17, 5);
        req(18, 5);
        chk("t3_held19", bus.moving_up, 0);
        chk("t3_pend19", bus.pending, 16'h0020);
        goto(24);
        chk("t3_door24", bus.door_open, 1);
        goto(25);
        chk("t3_idle25", bus.moving_up, 0);
        goto(26);
        chk("t3_move26", bus.moving_up, 1);
        req(29, 5);
        chk("t3_clr30", bus.pending, 0);
        goto(31);
        chk("t3_clr31", bus.pending, 0);
        goto(40);

        // Reset mid-travel loses calls
        start();
        req(0, 0);
        goto(6);
        chk("t4_f4", bus.current_floor, 4);
        chk("t4_down", bus.moving_down, 1);
        chk("t4_pend", bus.pending, 16'h0001);
        goto(7);
        reset = 1'b1;
        goto(8);
        chk("t4_rfloor", bus.current_floor, 0);
        chk("t4_rpend", bus.pending, 0);
        chk("t4_rdoor", bus.door_open, 1);
        chk("t4_rdn", bus.moving_down, 0);
        reset = 1'b0;
        goto(12);
        chk("t4_stay", bus.moving_down | bus.moving_up, 0);
        chk("t4_floor", bus.current_floor, 0);

`ifdef ELEV_ESTOP_EN
        // E-stop for 5 cycles at travel count 2
        start();
        expect_arr(3, 19);
        req(0, 3);
        goto(4);
        bus.estop = 1'b1;
        goto(5);
        chk("t5_up", bus.moving_up, 0);
        chk("t5_door", bus.door_open, 0);
        chk("t5_floor", bus.current_floor, 0);
        req(6, 5);
        chk("t5_pend", bus.pending, 16'h0028);
        goto(9);
        chk("t5_held", bus.moving_up, 0);
        bus.estop = 1'b0;
        goto(10);
        chk("t5_resume", bus.moving_up, 1);
        goto(11);
        chk("t5_f1", bus.current_floor, 1);
        expect_arr(5, 36);
        goto(46);
`endif

        // 12-floor car: out-of-range then top floor
        start();
        err12_q.push_back(t0 + 1);
        bus12.req_valid = 1'b1;
        bus12.req_floor = 4'd15;
        goto(1);
        bus12.req_valid = 1'b0;
        chk("t6_err", bus12.req_err, 1);
        chk("t6_pend", bus12.pending, 0);
        goto(2);
        chk("t6_err_off", bus12.req_err, 0);
        goto(3);
        chk("t6_still", bus12.moving_up, 0);
        chk("t6_door", bus12.door_open, 1);
        e.fl = 11;
        e.cy = t0 + 50;
        arr12_q.push_back(e);
        goto(4);
        bus12.req_valid = 1'b1;
        bus12.req_floor = 4'd11;
        goto(5);
        bus12.req_valid = 1'b0;
        chk("t6_pend11", bus12.pending, 12'h800);
        goto(6);
        chk("t6_move", bus12.moving_up, 1);
        goto(60);
        chk("t6_top", bus12.current_floor, 11);
        chk("t6_stop", bus12.moving_up, 0);

        for (int i = 0; i < 200; i++) begin
            if (arr_q.size() == 0 && arr12_q.size() == 0 &&
                err12_q.size() == 0)
                break;
            @(negedge clk);
        end
        chk("arr_left", arr_q.size(), 0);
        chk("arr12_left", arr12_q.size(), 0);
        chk("err12_left", err12_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
